// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit controller:
//   - uart_state_e  : frame FSM state encoding (3-bit)
//   - PAR_EVEN/ODD  : encoding of the par_typ input
//   - UART_IDLE_LVL : level of the serial line when no frame is being sent
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN      = 1'b0;
  localparam logic PAR_ODD       = 1'b1;
  localparam logic UART_IDLE_LVL = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_tx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl_if
// Byte-source / controller handshake plus the serial-side outputs.
//   p_data     : byte to transmit (sampled on an accept edge)
//   data_valid : byte available
//   par_en     : 1 = insert parity bit
//   par_typ    : 0 = even, 1 = odd
//   tx_out     : serial line, idle high
//   busy       : frame in progress
//   frame_done : one-cycle pulse during the stop bit
// master = byte source, slave = uart_tx_ctrl.
// -----------------------------------------------------------------------------
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output p_data, data_valid, par_en, par_typ,
    input  tx_out, busy, frame_done
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ,
    output tx_out, busy, frame_done
  );

endinterface : uart_tx_ctrl_if

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Shift register and bit counter for the data portion of a UART frame.
//   CLK          : baud-rate clock
//   RST          : asynchronous active-low reset
//   i_load       : capture i_data, clear the bit counter
//   i_data       : byte to serialise
//   i_shift_en   : high in every DATA cycle; shift right, count one bit
//   o_ser_data   : the data bit to be driven on the line in the next cycle
//   o_ser_done   : current DATA cycle carries the last data bit
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_shift_en,
  output logic                  o_ser_data,
  output logic                  o_ser_done
);

  localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_shifted = r_shift >> 1;

  // NOTE: the shift register is a handful of flops, not a RAM, so it is
  // cleared on reset like every other piece of state in this block.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= '0;
    end else if (i_shift_en) begin
      r_shift <= w_shifted;
      // Hold at the last index so the counter never wraps.
      if (r_cnt != LAST_BIT) r_cnt <= r_cnt + 1'b1;
    end
  end

  // The controller registers its output from the next state, so it needs the
  // bit that will be on the line next cycle: bit 0 when entering DATA, the
  // post-shift bit 0 while already inside DATA.
  assign o_ser_data = i_shift_en ? w_shifted[0] : r_shift[0];
  assign o_ser_done = (r_cnt == LAST_BIT);

endmodule : uart_tx_serializer

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit controller: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, stop bit; one bit per CLK (the baud clock).
//   CLK : baud-rate clock, rising edge
//   RST : asynchronous active-low reset (line returns to idle at once)
//   bus : uart_tx_ctrl_if.slave (p_data, data_valid, par_en, par_typ in;
//         tx_out, busy, frame_done out)
// A byte is accepted when data_valid=1 in IDLE or in STOP (back-to-back).
// All outputs are registered and decoded from the next state, so each output
// value lines up with the state the FSM is in.
// -----------------------------------------------------------------------------
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input logic           CLK,
  input logic           RST,
  uart_tx_ctrl_if.slave bus
);

  uart_state_e r_state;
  uart_state_e w_state_nxt;

  logic r_par_en;
  logic r_par_bit;
  logic r_tx_out;
  logic r_busy;
  logic r_frame_done;

  logic w_accept;
  logic w_par_bit;
  logic w_shift_en;
  logic w_ser_data;
  logic w_ser_done;
  logic w_tx_nxt;
  logic w_busy_nxt;
  logic w_done_nxt;

  assign w_accept   = bus.data_valid && ((r_state == ST_IDLE) || (r_state == ST_STOP));
  assign w_shift_en = (r_state == ST_DATA);
  // Parity is taken from the byte as it is latched, never from p_data later.
  assign w_par_bit  = (bus.par_typ == PAR_EVEN) ? (^bus.p_data) : (~^bus.p_data);

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .CLK        (CLK),
    .RST        (RST),
    .i_load     (w_accept),
    .i_data     (bus.p_data),
    .i_shift_en (w_shift_en),
    .o_ser_data (w_ser_data),
    .o_ser_done (w_ser_done)
  );

  // NOTE: every variable is given a default before the case statements, so
  // no path through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = UART_IDLE_LVL;
    w_busy_nxt  = 1'b1;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_START;
      ST_START:  w_state_nxt = ST_DATA;
      ST_DATA:   if (w_ser_done) w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: w_state_nxt = ST_STOP;
      ST_STOP:   w_state_nxt = w_accept ? ST_START : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase

    unique case (w_state_nxt)
      ST_IDLE:   w_busy_nxt = 1'b0;
      ST_START:  w_tx_nxt   = ~UART_IDLE_LVL;
      ST_DATA:   w_tx_nxt   = w_ser_data;
      ST_PARITY: w_tx_nxt   = r_par_bit;
      ST_STOP:   w_done_nxt = 1'b1;
      default:   w_busy_nxt = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_par_en     <= 1'b0;
      r_par_bit    <= 1'b0;
      r_tx_out     <= UART_IDLE_LVL;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tx_out     <= w_tx_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_done_nxt;
      if (w_accept) begin
        r_par_en  <= bus.par_en;
        r_par_bit <= w_par_bit;
      end
    end
  end

  assign bus.tx_out     = r_tx_out;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;

endmodule : uart_tx_ctrl

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Self-checking bench for uart_tx_ctrl. Expected per-cycle line states
// {tx_out, busy, frame_done} are queued when a byte is offered and popped on
// each falling edge while the frame plays out.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  tx;
    logic  busy;
    logic  done;
    string name;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic       exp_par;  // expected parity bit on the line
    int         exp_len;  // expected frame length in cycles
    bit         mid;      // disturb p_data/par_typ during DATA
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got tx/busy/done=%b, expected %b", name, act, exp);
  endtask

  task automatic push(input logic tx, input logic b, input logic dn, input string name);
    exp_t e;
    e.tx = tx; e.busy = b; e.done = dn; e.name = name;
    sb.push_back(e);
  endtask

  // Frame shape comes from the table's expected length and parity value.
  task automatic push_frame(input logic [7:0] d, input int len, input logic par, input string tag);
    push(1'b0, 1'b1, 1'b0, {tag, "_start"});
    for (int i = 0; i < 8; i++) push(d[i], 1'b1, 1'b0, $sformatf("%s_d%0d", tag, i));
    if (len == 11) push(par, 1'b1, 1'b0, {tag, "_parity"});
    push(1'b1, 1'b1, 1'b1, {tag, "_stop"});
  endtask

  task automatic check_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_empty: got no expectation at cycle %0d, expected one", i);
      end else begin
        e = sb.pop_front();
        check(e.name, {bus.tx_out, bus.busy, bus.frame_done}, {e.tx, e.busy, e.done});
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    bus.p_data     = v.d;
    bus.par_en     = v.pe;
    bus.par_typ    = v.pt;
    bus.data_valid = 1'b1;
    push_frame(v.d, v.exp_len, v.exp_par, tag);
    push(1'b1, 1'b0, 1'b0, {tag, "_idle"});
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
    if (v.mid) begin
      check_cycles(3);
      bus.p_data  = 8'hFF;
      bus.par_typ = ~bus.par_typ;
      check_cycles(v.exp_len + 1 - 3);
    end else begin
      check_cycles(v.exp_len + 1);
    end
  endtask

  vec_t vecs[6];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    vecs[0] = '{d: 8'h05, pe: 1'b1, pt: 1'b0, exp_par: 1'b0, exp_len: 11, mid: 1'b0};
    vecs[1] = '{d: 8'h04, pe: 1'b1, pt: 1'b0, exp_par: 1'b1, exp_len: 11, mid: 1'b0};
    vecs[2] = '{d: 8'h07, pe: 1'b1, pt: 1'b1, exp_par: 1'b0, exp_len: 11, mid: 1'b0};
    vecs[3] = '{d: 8'h07, pe: 1'b0, pt: 1'b1, exp_par: 1'b0, exp_len: 10, mid: 1'b0};
    vecs[4] = '{d: 8'h00, pe: 1'b1, pt: 1'b1, exp_par: 1'b1, exp_len: 11, mid: 1'b0};
    vecs[5] = '{d: 8'h05, pe: 1'b1, pt: 1'b0, exp_par: 1'b0, exp_len: 11, mid: 1'b1};

    bus.p_data     = 8'h00;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    bus.data_valid = 1'b0;

    // Reset state, with a byte offered during reset that must be ignored.
    #1 rst_n = 1'b0;
    bus.data_valid = 1'b1;
    #11;
    check("reset_state", {bus.tx_out, bus.busy, bus.frame_done}, 3'b100);
    @(negedge clk);
    bus.data_valid = 1'b0;
    rst_n = 1'b1;
    push(1'b1, 1'b0, 1'b0, "post_reset_idle0");
    push(1'b1, 1'b0, 1'b0, "post_reset_idle1");
    check_cycles(2);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: 0xA5 without parity, then 0x3C with even parity,
    // data_valid held across the boundary. par_en changes mid-frame too.
    @(negedge clk);
    bus.p_data     = 8'hA5;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    bus.data_valid = 1'b1;
    push_frame(8'hA5, 10, 1'b0, "b2b_a5");
    @(posedge clk);
    #1;
    bus.p_data  = 8'h3C;
    bus.par_en  = 1'b1;
    bus.par_typ = 1'b0;
    push_frame(8'h3C, 11, 1'b0, "b2b_3c");
    push(1'b1, 1'b0, 1'b0, "b2b_idle");
    check_cycles(10);
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
    check_cycles(12);

    // Reset during the 3rd data bit.
    @(negedge clk);
    bus.p_data     = 8'h05;
    bus.par_en     = 1'b1;
    bus.par_typ    = 1'b0;
    bus.data_valid = 1'b1;
    push_frame(8'h05, 11, 1'b0, "rst_mid");
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
    check_cycles(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_async", {bus.tx_out, bus.busy, bus.frame_done}, 3'b100);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'b0, $sformatf("rst_release_idle%0d", i));
    check_cycles(4);

    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_tx_ctrl

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller. Accepts one byte per handshake and sequences the serial frame on a single line: start bit, 8 data bits LSB first, optional parity bit, stop bit. It owns the frame FSM, bit counter and shift register. It computes parity on the latched byte, so the parity datapath cannot be corrupted by input changes mid-frame. It sits between the TX byte source (FIFO or register) and the pad; one bit is sent per CLK cycle, and CLK is the baud-rate clock supplied by an external prescaler.

Parameters:
DATA_WIDTH, 8, data bits per frame.

Ports:
CLK  input  1  baud-rate clock, rising edge.
RST  input  1  asynchronous, active-low reset.
p_data  input  DATA_WIDTH  byte to transmit; sampled only on an accept edge.
data_valid  input  1  byte available; accepted when the controller is ready.
par_en  input  1  1 = insert parity bit; sampled on the accept edge.
par_typ  input  1  0 = even, 1 = odd; sampled on the accept edge.
tx_out  output  1  serial line, idle high.
busy  output  1  frame in progress.
frame_done  output  1  one-cycle pulse during the stop-bit cycle.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, tx_out=1, busy=0, frame_done=0, bit counter=0, shift register=0.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered and decoded from the next state, so each output value coincides with the current state.
- Accept edge: a rising edge where data_valid=1 and the state is IDLE, or the state is STOP (back-to-back). On it, latch p_data into the shift register, and latch par_en and parity_bit. parity_bit = ^p_data for even, ~^p_data for odd.
- IDLE -> START on an accept edge; otherwise stay. In IDLE: tx_out=1, busy=0.
- START: 1 cycle, tx_out=0, busy=1. Then go to DATA with counter=0.
- DATA: DATA_WIDTH cycles. tx_out = shift register bit 0; shift right every cycle; counter increments.
  - Leaving DATA: at counter = DATA_WIDTH-1, go to PARITY if the latched par_en=1, else to STOP.
- PARITY: 1 cycle, tx_out = latched parity_bit.
- STOP: 1 cycle, tx_out=1, frame_done=1, busy=1.
  - If data_valid=1 on this edge, accept and go directly to START (no idle gap); else go to IDLE.
- Frame length: 10 cycles (par_en=0) or 11 cycles (par_en=1), counted from the first START cycle.
- Latency: the start bit appears in the cycle immediately after the accept edge.
- data_valid in START, DATA or PARITY is ignored; the source holds it until it sees busy=0 or the STOP cycle. p_data and par_* changes mid-frame have no effect.
- RST asserted mid-frame: the frame is abandoned immediately, tx_out=1 asynchronously. After release, the block starts in IDLE and sends no partial frame.
- Counter width = clog2(DATA_WIDTH); no wrap beyond DATA_WIDTH-1 is reachable.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit);
  - PAR_EVEN=0, PAR_ODD=1;
  - UART_IDLE_LVL=1.
- One sub-module is natural: uart_tx_serializer. It holds the shift register and bit counter, takes load/shift_en, and returns ser_data and ser_done. The FSM, parity latch and output mux stay in uart_tx_ctrl.

Test Plan:
- Even parity, byte 0x05: par_en=1, par_typ=0, one data_valid pulse -> tx_out sequence 0, 1,0,1,0,0,0,0,0, 0, 1. busy high for 11 cycles; frame_done pulses in cycle 11.
- Even parity, byte 0x04: par_en=1, par_typ=0 -> data bits 0,0,1,0,0,0,0,0, parity bit 1, stop 1.
- Odd parity, byte 0x07: par_en=1, par_typ=1 -> data bits 1,1,1,0,0,0,0,0, parity bit 0. Then par_en=0 with 0x07 -> 10-cycle frame, no parity slot.
- Back-to-back: data_valid held high with 0xA5 then 0x3C -> second START directly follows the first STOP. tx_out never returns to 1 for an extra idle cycle; busy stays high across the frame boundary.
- Mid-frame isolation: after accepting 0x05, change p_data to 0xFF and toggle par_typ during DATA -> the frame still matches the 0x05 even-parity pattern.
- Reset mid-frame: drop RST during the 3rd data bit -> tx_out=1 and busy=0 immediately. After release with data_valid=0, the line stays at 1.
